// File: rtl/lane_dropper_multi_if.sv
// rtl/lane_dropper_multi_if.sv - key inputs and note/score outputs of one arrow lane
//
// Purpose: bundles the keyboard inputs and the sprite/scoreboard outputs of a
// lane_dropper_multi instance.
// Signals:
//   keycode, keycode_second  8-bit USB keycodes (driven by the keyboard side)
//   note_x                   lane X position (pixels)
//   note_y                   per-slot top Y, slot i on bits [10i+9:10i]
//   note_active              per-slot visible/in-flight flag
//   hit_pulse, miss_pulse    one-frame event pulses
//   score, combo             saturating counters
//   done                     song finished
// Modports: master = keyboard/display side, slave = lane logic.
interface lane_dropper_multi_if #(
    parameter int NUM_NOTES = 4,
    parameter int SCORE_W   = 8
);
    logic [7:0]              keycode;
    logic [7:0]              keycode_second;
    logic [9:0]              note_x;
    logic [10*NUM_NOTES-1:0] note_y;
    logic [NUM_NOTES-1:0]    note_active;
    logic                    hit_pulse;
    logic                    miss_pulse;
    logic [SCORE_W-1:0]      score;
    logic [SCORE_W-1:0]      combo;
    logic                    done;

    modport master (
        output keycode, keycode_second,
        input  note_x, note_y, note_active, hit_pulse, miss_pulse, score, combo, done
    );

    modport slave (
        input  keycode, keycode_second,
        output note_x, note_y, note_active, hit_pulse, miss_pulse, score, combo, done
    );
endinterface

// File: rtl/lane_dropper_multi.sv
// rtl/lane_dropper_multi.sv - per-lane note spawner, mover and hit/miss judge
//
// Purpose: one arrow lane of the rhythm game. Spawns up to NUM_NOTES notes at
// scheduled frame counts, moves them down the lane, judges key presses against
// the hit window and keeps score/combo. Advances once per frame_clk edge.
// Ports:
//   frame_clk  frame clock, all state changes on its rising edge
//   Reset      synchronous active-low reset
//   bus        lane_dropper_multi_if.slave (keycodes in; note_x/note_y/
//              note_active/hit_pulse/miss_pulse/score/combo/done out)
module lane_dropper_multi #(
    parameter int                    LANE_X      = 100,
    parameter int                    NUM_NOTES   = 4,
    parameter logic [NUM_NOTES*12-1:0] SPAWN_TIMES = {12'd1440, 12'd1400, 12'd1360, 12'd1320},
    parameter logic [7:0]            HIT_KEY     = 8'h1a,
    parameter logic [7:0]            START_KEY   = 8'h2c,
    parameter logic [7:0]            CLEAR_KEY   = 8'h01,
    parameter int                    Y_START     = 100,
    parameter int                    Y_MAX       = 400,
    parameter int                    NOTE_H      = 40,
    parameter int                    HIT_LO      = 340,
    parameter int                    HIT_HI      = 400,
    parameter int                    SPEED       = 1,
    parameter int                    SCORE_W     = 8
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    lane_dropper_multi_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Y math is 11 bits wide so a note near the bottom never wraps at 1023.
    localparam logic [10:0]        Y_START_V = 11'(Y_START);
    localparam logic [10:0]        Y_MAX_V   = 11'(Y_MAX);
    localparam logic [10:0]        NOTE_H_V  = 11'(NOTE_H);
    localparam logic [10:0]        HIT_LO_V  = 11'(HIT_LO);
    localparam logic [10:0]        HIT_HI_V  = 11'(HIT_HI);
    localparam logic [10:0]        SPEED_V   = 11'(SPEED);
    localparam logic [SCORE_W-1:0] CNT_SAT   = {SCORE_W{1'b1}};

    state_t               state_q, state_d;
    logic [11:0]          frame_cnt_q, frame_cnt_d;
    logic [NUM_NOTES-1:0] spawned_q, spawned_d;
    logic [NUM_NOTES-1:0] active_q, active_d;
    logic [10:0]          y_q [NUM_NOTES];
    logic [10:0]          y_d [NUM_NOTES];
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   combo_q, combo_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic                 key_prev_q;
    logic                 key_now;
    logic                 press;
    logic                 hit_taken;
    logic [10:0]          bottom;

    assign key_now = (bus.keycode == HIT_KEY) | (bus.keycode_second == HIT_KEY);
    assign press   = key_now & ~key_prev_q;

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            spawned_q   <= '0;
            active_q    <= '0;
            for (int i = 0; i < NUM_NOTES; i++) begin
                y_q[i] <= Y_START_V;
            end
            score_q     <= '0;
            combo_q     <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            key_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            spawned_q   <= spawned_d;
            active_q    <= active_d;
            for (int i = 0; i < NUM_NOTES; i++) begin
                y_q[i] <= y_d[i];
            end
            score_q     <= score_d;
            combo_q     <= combo_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            key_prev_q  <= key_now;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        spawned_d   = spawned_q;
        active_d    = active_q;
        for (int i = 0; i < NUM_NOTES; i++) begin
            y_d[i] = y_q[i];
        end
        score_d     = score_q;
        combo_d     = combo_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        hit_taken   = 1'b0;
        bottom      = '0;

        case (state_q)
            IDLE: begin
                frame_cnt_d = '0;
                spawned_d   = '0;
                active_d    = '0;
                for (int i = 0; i < NUM_NOTES; i++) begin
                    y_d[i] = Y_START_V;
                end
                score_d = '0;
                combo_d = '0;
                if (bus.keycode == START_KEY) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                // Ascending slot order makes the first eligible slot the one
                // hit, so a single press never takes more than one note.
                for (int i = 0; i < NUM_NOTES; i++) begin
                    bottom = y_q[i] + NOTE_H_V;
                    if (active_q[i]) begin
                        if (bottom >= Y_MAX_V) begin
                            active_d[i] = 1'b0;
                            miss_d      = 1'b1;
                        end else begin
                            y_d[i] = y_q[i] + SPEED_V;
                            if (press && !hit_taken &&
                                bottom >= HIT_LO_V && bottom < HIT_HI_V) begin
                                active_d[i] = 1'b0;
                                hit_taken   = 1'b1;
                            end
                        end
                    end else if (!spawned_q[i] &&
                                 frame_cnt_q == SPAWN_TIMES[12*i +: 12]) begin
                        active_d[i]  = 1'b1;
                        spawned_d[i] = 1'b1;
                        y_d[i]       = Y_START_V;
                    end
                end

                hit_d = hit_taken;
                if (hit_taken && score_q != CNT_SAT) begin
                    score_d = score_q + SCORE_W'(1);
                end

                if (miss_d && hit_taken) begin
                    combo_d = SCORE_W'(1);
                end else if (miss_d) begin
                    combo_d = '0;
                end else if (hit_taken && combo_q != CNT_SAT) begin
                    combo_d = combo_q + SCORE_W'(1);
                end

                if (frame_cnt_q != 12'hFFF) begin
                    frame_cnt_d = frame_cnt_q + 12'd1;
                end

                if ((&spawned_d) && (active_d == '0)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                active_d = '0;
                if (bus.keycode == CLEAR_KEY) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.note_x      = 10'(LANE_X);
    assign bus.note_active = active_q;
    assign bus.hit_pulse   = hit_q;
    assign bus.miss_pulse  = miss_q;
    assign bus.score       = score_q;
    assign bus.combo       = combo_q;
    assign bus.done        = (state_q == DONE);

    for (genvar g = 0; g < NUM_NOTES; g++) begin : g_pack
        assign bus.note_y[10*g +: 10] = y_q[g][9:0];
    end
endmodule

// File: tb/tb_lane_dropper_multi.sv
// tb/tb_lane_dropper_multi.sv - directed and randomized checks of lane_dropper_multi against a frame model
module tb_lane_dropper_multi;
    localparam logic [7:0] K_HIT   = 8'h1a;
    localparam logic [7:0] K_START = 8'h2c;
    localparam logic [7:0] K_CLEAR = 8'h01;
    localparam int Y_START = 100;
    localparam int Y_MAX   = 400;
    localparam int NOTE_H  = 40;
    localparam int HIT_LO  = 340;
    localparam int HIT_HI  = 400;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DONE  = 2;

    logic frame_clk = 1'b0;
    logic Reset;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   a_busy      = 1'b1;

    always #5 frame_clk = ~frame_clk;

    lane_dropper_multi_if #(.NUM_NOTES(1), .SCORE_W(8)) ia ();
    lane_dropper_multi_if #(.NUM_NOTES(6), .SCORE_W(2)) ib ();

    lane_dropper_multi #(
        .NUM_NOTES(1),
        .SPAWN_TIMES(12'd1440)
    ) dut_a (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .bus(ia)
    );

    lane_dropper_multi #(
        .NUM_NOTES(6),
        .SCORE_W(2),
        .SPEED(2),
        .SPAWN_TIMES({12'd60, 12'd50, 12'd40, 12'd30, 12'd20, 12'd10})
    ) dut_b (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .bus(ib)
    );

    // Lane configurations seen by the model: 0 = dut_a, 1 = dut_b.
    int c_n     [2] = '{1, 6};
    int c_speed [2] = '{1, 2};
    int c_smax  [2] = '{255, 3};
    int c_spawn [2][8];

    // Behavioural state of each lane.
    int m_state [2];
    int m_fc    [2];
    int m_score [2];
    int m_combo [2];
    bit m_kprev [2];
    bit m_hit   [2];
    bit m_miss  [2];
    bit m_sp    [2][8];
    bit m_act   [2][8];
    int m_y     [2][8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic run_frames(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    task automatic clear_song(input int d);
        m_fc[d] = 0;
        for (int i = 0; i < 8; i++) begin
            m_sp[d][i]  = 1'b0;
            m_act[d][i] = 1'b0;
            m_y[d][i]   = Y_START;
        end
    endtask

    // One frame of the lane's rules, applied to the model of lane d.
    task automatic model_step(input int d, input logic [7:0] kc, input logic [7:0] kc2, input logic rst);
        bit key_now;
        bit press;
        bit any_miss;
        bit all_spawned;
        bit any_active;
        bit missing [8];
        int hit_slot;
        int bot;
        key_now  = (kc == K_HIT) || (kc2 == K_HIT);
        m_hit[d]  = 1'b0;
        m_miss[d] = 1'b0;
        if (!rst) begin
            m_state[d] = S_IDLE;
            m_score[d] = 0;
            m_combo[d] = 0;
            m_kprev[d] = 1'b0;
            clear_song(d);
            return;
        end
        press      = key_now && !m_kprev[d];
        m_kprev[d] = key_now;
        case (m_state[d])
            S_IDLE: begin
                clear_song(d);
                m_score[d] = 0;
                m_combo[d] = 0;
                if (kc == K_START) m_state[d] = S_RUN;
            end
            S_RUN: begin
                any_miss = 1'b0;
                hit_slot = -1;
                for (int i = 0; i < 8; i++) missing[i] = 1'b0;
                for (int i = 0; i < c_n[d]; i++) begin
                    missing[i] = m_act[d][i] && (m_y[d][i] + NOTE_H >= Y_MAX);
                    any_miss   = any_miss || missing[i];
                end
                if (press) begin
                    for (int i = 0; i < c_n[d]; i++) begin
                        bot = m_y[d][i] + NOTE_H;
                        if (hit_slot < 0 && m_act[d][i] && !missing[i] && bot >= HIT_LO && bot < HIT_HI)
                            hit_slot = i;
                    end
                end
                for (int i = 0; i < c_n[d]; i++) begin
                    if (m_act[d][i]) begin
                        if (missing[i]) begin
                            m_act[d][i] = 1'b0;
                        end else begin
                            m_y[d][i] = m_y[d][i] + c_speed[d];
                            if (i == hit_slot) m_act[d][i] = 1'b0;
                        end
                    end
                end
                for (int i = 0; i < c_n[d]; i++) begin
                    if (!m_sp[d][i] && m_fc[d] == c_spawn[d][i]) begin
                        m_sp[d][i]  = 1'b1;
                        m_act[d][i] = 1'b1;
                        m_y[d][i]   = Y_START;
                    end
                end
                if (hit_slot >= 0 && m_score[d] < c_smax[d]) m_score[d]++;
                if (any_miss && hit_slot >= 0)      m_combo[d] = 1;
                else if (any_miss)                  m_combo[d] = 0;
                else if (hit_slot >= 0 && m_combo[d] < c_smax[d]) m_combo[d]++;
                if (m_fc[d] < 4095) m_fc[d]++;
                m_hit[d]  = (hit_slot >= 0);
                m_miss[d] = any_miss;
                all_spawned = 1'b1;
                any_active  = 1'b0;
                for (int i = 0; i < c_n[d]; i++) begin
                    all_spawned = all_spawned && m_sp[d][i];
                    any_active  = any_active || m_act[d][i];
                end
                if (all_spawned && !any_active) m_state[d] = S_DONE;
            end
            default: begin
                for (int i = 0; i < 8; i++) m_act[d][i] = 1'b0;
                if (kc == K_CLEAR) m_state[d] = S_IDLE;
            end
        endcase
    endtask

    function automatic logic [63:0] model_y(input int d);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < c_n[d]; i++) v[10*i +: 10] = 10'(m_y[d][i]);
        return v;
    endfunction

    function automatic logic [7:0] model_act(input int d);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < c_n[d]; i++) v[i] = m_act[d][i];
        return v;
    endfunction

    task automatic compare_lane(input int d, input string tag, input logic [63:0] y, input logic [7:0] act,
                                input logic hit, input logic miss, input logic done,
                                input logic [7:0] score, input logic [7:0] combo, input logic [9:0] x);
        check($sformatf("%s.note_y", tag), y, model_y(d));
        check($sformatf("%s.note_active", tag), 64'(act), 64'(model_act(d)));
        check($sformatf("%s.hit_pulse", tag), 64'(hit), 64'(m_hit[d]));
        check($sformatf("%s.miss_pulse", tag), 64'(miss), 64'(m_miss[d]));
        check($sformatf("%s.done", tag), 64'(done), 64'(m_state[d] == S_DONE));
        check($sformatf("%s.score", tag), 64'(score), 64'(m_score[d]));
        check($sformatf("%s.combo", tag), 64'(combo), 64'(m_combo[d]));
        check($sformatf("%s.note_x", tag), 64'(x), 64'd100);
    endtask

    // Model advances on each edge with the inputs the DUT saw; outputs compared 2 time units later.
    initial begin
        forever begin
            @(posedge frame_clk);
            model_step(0, ia.keycode, ia.keycode_second, Reset);
            model_step(1, ib.keycode, ib.keycode_second, Reset);
            #2;
            compare_lane(0, "a", 64'(ia.note_y), 8'(ia.note_active), ia.hit_pulse, ia.miss_pulse,
                         ia.done, 8'(ia.score), 8'(ia.combo), ia.note_x);
            compare_lane(1, "b", 64'(ib.note_y), 8'(ib.note_active), ib.hit_pulse, ib.miss_pulse,
                         ib.done, 8'(ib.score), 8'(ib.combo), ib.note_x);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pick_key(input int hit_pct);
        int r;
        r = $urandom_range(0, 99);
        if (r < 3)            return K_START;
        if (r < 6)            return K_CLEAR;
        if (r < 6 + hit_pct)  return K_HIT;
        if (r < 85)           return 8'h00;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) begin
            c_spawn[0][i] = 1440;
            c_spawn[1][i] = 10 + 10 * i;
        end
        Reset = 1'b0;
        ia.keycode = 8'h00; ia.keycode_second = 8'h00;
        ib.keycode = 8'h00; ib.keycode_second = 8'h00;
        run_frames(3);
        check("reset.a_active", 64'(ia.note_active), 64'd0);
        check("reset.b_y0", 64'(ib.note_y[9:0]), 64'd100);
        check("reset.b_score", 64'(ib.score), 64'd0);
        check("reset.b_done", 64'(ib.done), 64'd0);
        Reset = 1'b1;

        // Lane b: reset in the middle of a song with two notes in flight.
        ib.keycode = K_START; run_frames(1); ib.keycode = 8'h00;
        run_frames(22);
        check("b.two_active", 64'(ib.note_active), 64'b000011);
        check("b.y0_pre_reset", 64'(ib.note_y[9:0]), 64'd122);
        Reset = 1'b0; run_frames(1); Reset = 1'b1;
        check("b.reset_active", 64'(ib.note_active), 64'd0);
        check("b.reset_score", 64'(ib.score), 64'd0);
        check("b.reset_combo", 64'(ib.combo), 64'd0);
        run_frames(30);
        check("b.idle_no_spawn", 64'(ib.note_active), 64'd0);
        check("b.idle_not_done", 64'(ib.done), 64'd0);

        // Lane b: two notes in the window, same-frame miss+hit, score saturation.
        ib.keycode = K_START; run_frames(1); ib.keycode = 8'h00;
        run_frames(124);
        ib.keycode = K_HIT; run_frames(1); ib.keycode = 8'h00;
        check("b.first_press_hit", 64'(ib.hit_pulse), 64'd1);
        check("b.first_press_active", 64'(ib.note_active), 64'b111110);
        check("b.first_press_score", 64'(ib.score), 64'd1);
        run_frames(2);
        ib.keycode_second = K_HIT; run_frames(1); ib.keycode_second = 8'h00;
        check("b.second_press_active", 64'(ib.note_active), 64'b111100);
        check("b.second_press_score", 64'(ib.score), 64'd2);
        check("b.second_press_combo", 64'(ib.combo), 64'd2);
        run_frames(33);
        ib.keycode = K_HIT; run_frames(1); ib.keycode = 8'h00;
        check("b.missnhit_miss", 64'(ib.miss_pulse), 64'd1);
        check("b.missnhit_hit", 64'(ib.hit_pulse), 64'd1);
        check("b.missnhit_combo", 64'(ib.combo), 64'd1);
        check("b.missnhit_active", 64'(ib.note_active), 64'b110000);
        run_frames(7);
        ib.keycode = K_HIT; run_frames(1); ib.keycode = 8'h00;
        check("b.sat_score", 64'(ib.score), 64'd3);
        check("b.fourth_combo", 64'(ib.combo), 64'd2);
        run_frames(9);
        ib.keycode = K_HIT; run_frames(1); ib.keycode = 8'h00;
        check("b.fifth_score", 64'(ib.score), 64'd3);
        check("b.fifth_combo", 64'(ib.combo), 64'd3);
        check("b.fifth_done", 64'(ib.done), 64'd1);

        fork
            begin
                // Lane a song 1: note left alone falls into the miss line.
                ia.keycode = K_START; run_frames(1); ia.keycode = 8'h00;
                run_frames(1441);
                check("a.spawn_active", 64'(ia.note_active), 64'd1);
                check("a.spawn_y", 64'(ia.note_y), 64'd100);
                run_frames(260);
                check("a.bottom_y", 64'(ia.note_y), 64'd360);
                check("a.bottom_no_miss", 64'(ia.miss_pulse), 64'd0);
                run_frames(1);
                check("a.miss_pulse", 64'(ia.miss_pulse), 64'd1);
                check("a.miss_combo", 64'(ia.combo), 64'd0);
                check("a.miss_done", 64'(ia.done), 64'd1);
                run_frames(1);
                check("a.miss_pulse_one_frame", 64'(ia.miss_pulse), 64'd0);

                // Song 2: hit on the secondary keycode at bottom 350.
                ia.keycode = K_CLEAR; run_frames(1);
                ia.keycode = K_START; run_frames(1); ia.keycode = 8'h00;
                run_frames(1651);
                check("a.pre_hit_y", 64'(ia.note_y), 64'd310);
                ia.keycode_second = K_HIT; run_frames(1); ia.keycode_second = 8'h00;
                check("a.hit_pulse", 64'(ia.hit_pulse), 64'd1);
                check("a.hit_score", 64'(ia.score), 64'd1);
                check("a.hit_combo", 64'(ia.combo), 64'd1);
                check("a.hit_inactive", 64'(ia.note_active), 64'd0);
                check("a.hit_done", 64'(ia.done), 64'd1);
                run_frames(1);
                check("a.hit_pulse_one_frame", 64'(ia.hit_pulse), 64'd0);

                // Song 3: early press, hold through the window, re-press at bottom 360.
                ia.keycode = K_CLEAR; run_frames(1);
                ia.keycode = K_START; run_frames(1); ia.keycode = 8'h00;
                run_frames(1631);
                check("a.early_y", 64'(ia.note_y), 64'd290);
                ia.keycode = K_HIT; run_frames(24);
                ia.keycode = 8'h00; run_frames(6);
                check("a.held_no_hit_score", 64'(ia.score), 64'd0);
                check("a.held_still_active", 64'(ia.note_active), 64'd1);
                check("a.repress_y", 64'(ia.note_y), 64'd320);
                ia.keycode = K_HIT; run_frames(1); ia.keycode = 8'h00;
                check("a.repress_hit", 64'(ia.hit_pulse), 64'd1);
                check("a.repress_score", 64'(ia.score), 64'd1);
                run_frames(2);
                a_busy = 1'b0;
            end
            begin
                // Lane b: random keys while lane a runs its long songs.
                while (a_busy) begin
                    ib.keycode        = pick_key(25);
                    ib.keycode_second = pick_key(10);
                    run_frames(1);
                end
                ib.keycode = 8'h00;
                ib.keycode_second = 8'h00;
                run_frames(1);
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
